pc_fetch_queue: RTL and testbench

Parametrised program-counter and instruction-fetch front end, the successor to the single-cycle PC update. It holds the fetch PC and issues word requests to an instruction memory with arbitrary, in-order response latency, up to DEPTH requests in flight. Returned instructions are buffered with their PCs and handed to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and discards responses already in flight.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/pc_fetch_queue_if.sv | 41 ++++
 rtl/fetch_ring.sv | 68 ++++++
 rtl/pc_fetch_queue.sv | 91 +++++++++
 tb/tb_pc_fetch_queue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the fetch front end and downstream stages
// (decode and later pipeline stages reuse the instruction geometry and the
// canonical NOP encoding).
package fetch_pkg;

  localparam int              INSTR_W     = 32;
  localparam int              INSTR_BYTES = 4;
  localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_queue_if.sv
// pc_fetch_queue_if: bundles the redirect input, the instruction-memory
// request/response channel and the decode-side valid/ready channel.
//   master : the fetch unit (drives imem requests and the decode channel)
//   slave  : the environment (memory, branch unit, decode)
interface pc_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int XLEN = 64
);

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_ring.sv
// fetch_ring: DEPTH-entry ring of {pc, instr} with three pointers.
//   alloc : next entry to receive a PC when a request is issued
//   fill  : next entry to receive an instruction from memory
//   read  : entry currently presented to decode
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, reset          clock, synchronous active-high reset (pointers only)
//   flush               clears all pointers (redirect)
//   alloc_en/alloc_pc   record PC of an issued request
//   fill_en/fill_instr  record returned instruction
//   read_en             advance read pointer (decode handshake)
//   full, empty         occupancy flags
//   outstanding         requests issued but not yet answered (alloc - fill)
//   rd_pc, rd_instr     entry at the read pointer
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        alloc_en,
  input  logic [XLEN-1:0]             alloc_pc,
  input  logic                        fill_en,
  input  logic [INSTR_W-1:0]          fill_instr,
  input  logic                        read_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      outstanding,
  output logic [XLEN-1:0]             rd_pc,
  output logic [INSTR_W-1:0]          rd_instr
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]      alloc_ptr;
  logic [PW-1:0]      fill_ptr;
  logic [PW-1:0]      read_ptr;
  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + PW'(1);
      if (read_en)  read_ptr  <= read_ptr + PW'(1);
    end
  end

  // Storage is not reset; writers are already gated off during reset/flush.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[alloc_ptr[PW-2:0]]   <= alloc_pc;
    if (fill_en)  instr_mem[fill_ptr[PW-2:0]] <= fill_instr;
  end

  assign outstanding = alloc_ptr - fill_ptr;
  assign full        = ((alloc_ptr - read_ptr) == PW'(DEPTH));
  assign empty       = (fill_ptr == read_ptr);
  assign rd_pc       = pc_mem[read_ptr[PW-2:0]];
  assign rd_instr    = instr_mem[read_ptr[PW-2:0]];

endmodule

// File: rtl/pc_fetch_queue.sv
// pc_fetch_queue: fetch PC and instruction-fetch front end. Issues word
// requests to an in-order instruction memory (up to DEPTH in flight),
// buffers the returned instructions with their PCs, and hands them to
// decode over valid/ready. A redirect flushes the queue and arms a discard
// counter that swallows the responses still in flight.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    pc_fetch_queue_if.master (redirect, imem req/rsp, decode out)
module pc_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_fetch_queue_if.master     bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   discard;
  logic [PW-1:0]   discard_flush;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   outstanding;
  logic            full;
  logic            empty;
  logic            alloc_en;
  logic            fill_en;
  logic            read_en;
  logic            rsp_drop;

  // Request path is the only combinational output: redirect must suppress
  // a request in the same cycle.
  assign bus.imem_req_valid = !reset && !bus.redirect_valid &&
                              (discard == '0) && !full;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = !empty;

  assign alloc_en = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid && (discard != '0);
  // A response with nothing outstanding is a protocol error and is ignored.
  assign fill_en  = bus.imem_rsp_valid && (discard == '0) &&
                    (outstanding != '0) && !bus.redirect_valid && !reset;
  assign read_en  = !empty && bus.out_ready;

  // On redirect every in-flight request becomes a discard; a response
  // arriving in the same cycle is already consumed. discard>0 blocks new
  // requests, so pending never exceeds DEPTH.
  always_comb begin
    pending       = discard + outstanding;
    discard_flush = pending;
    if (bus.imem_rsp_valid && (pending != '0)) discard_flush = pending - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      discard  <= discard_flush;
    end else begin
      if (alloc_en) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (rsp_drop) discard  <= discard - PW'(1);
    end
  end

  fetch_ring #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.redirect_valid),
    .alloc_en    (alloc_en),
    .alloc_pc    (fetch_pc),
    .fill_en     (fill_en),
    .fill_instr  (bus.imem_rsp_data),
    .read_en     (read_en),
    .full        (full),
    .empty       (empty),
    .outstanding (outstanding),
    .rd_pc       (bus.out_pc),
    .rd_instr    (bus.out_instr)
  );

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue with a small in-order memory model of
// configurable latency. A second instance with a high RESET_PC checks PC
// wrap-around.
module tb_pc_fetch_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_queue_if #(.XLEN(64)) bus ();
  pc_fetch_queue_if #(.XLEN(64)) bus_hi ();

  pc_fetch_queue #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_fetch_queue #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DEPTH(4)) u_dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lat = 1;
  logic [63:0] q_addr[$];
  int          q_due[$];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // One clock: sample handshakes before the edge, then advance the memory.
  task automatic cycle();
    logic        rf;
    logic        pf;
    logic        rs;
    logic [63:0] ra;
    rf = bus.imem_req_valid && bus.imem_req_ready;
    ra = bus.imem_req_addr;
    pf = bus.imem_rsp_valid;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (pf && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (rf) begin
        q_addr.push_back(ra);
        q_due.push_back(cyc + lat);
      end
    end
    cyc++;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(q_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = 64'h0;
    bus.imem_req_ready    = 1'b1;
    bus.imem_rsp_valid    = 1'b0;
    bus.imem_rsp_data     = 32'h0;
    bus.out_ready         = 1'b1;
    bus_hi.redirect_valid = 1'b0;
    bus_hi.redirect_pc    = 64'h0;
    bus_hi.imem_req_ready = 1'b1;
    bus_hi.imem_rsp_valid = 1'b0;
    bus_hi.imem_rsp_data  = 32'h0;
    bus_hi.out_ready      = 1'b1;

    // Reset state, then 1-cycle memory streaming
    lat = 1;
    cycles(2);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check("rst_req_addr", bus.imem_req_addr, 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_hi_addr", bus_hi.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    reset = 1'b0;
    #1;
    check("first_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check("first_req_addr", bus.imem_req_addr, 64'h0);
    check("hi_req_valid", 64'(bus_hi.imem_req_valid), 64'h1);
    cycle();
    check("s1_req_addr", bus.imem_req_addr, 64'h4);
    check("s1_out_valid", 64'(bus.out_valid), 64'h0);
    check("hi_addr_fffc", bus_hi.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("s2_out_valid", 64'(bus.out_valid), 64'h1);
    check("s2_out_pc", bus.out_pc, 64'h0);
    check("s2_out_instr", 64'(bus.out_instr), 64'hC0DE_0000);
    check("hi_addr_wrap", bus_hi.imem_req_addr, 64'h0);
    cycle();
    check("s3_out_pc", bus.out_pc, 64'h4);
    check("s3_out_instr", 64'(bus.out_instr), 64'hC0DE_0004);
    cycle();
    check("s4_out_pc", bus.out_pc, 64'h8);
    check("s4_out_valid", 64'(bus.out_valid), 64'h1);

    // Decode stalled: exactly DEPTH requests, then resume at 0x10
    bus.out_ready = 1'b0;
    do_reset();
    cycles(4);
    check("full_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check("full_req_addr", bus.imem_req_addr, 64'h10);
    check("full_out_pc", bus.out_pc, 64'h0);
    cycles(2);
    check("full_hold_req", 64'(bus.imem_req_valid), 64'h0);
    check("full_hold_valid", 64'(bus.out_valid), 64'h1);
    bus.out_ready = 1'b1;
    #1;
    check("full_ready_req", 64'(bus.imem_req_valid), 64'h0);
    cycle();
    check("resume_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check("resume_req_addr", bus.imem_req_addr, 64'h10);
    check("resume_out_pc", bus.out_pc, 64'h4);
    check("resume_out_instr", 64'(bus.out_instr), 64'hC0DE_0004);

    // Latency 3, redirect to 0x1002 with three requests in flight
    lat = 3;
    do_reset();
    cycles(3);
    check("l3_out_valid", 64'(bus.out_valid), 64'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1002;
    #1;
    check("redir_req_blocked", 64'(bus.imem_req_valid), 64'h0);
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    check("d1_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check("d1_req_addr", bus.imem_req_addr, 64'h1000);
    check("d1_out_valid", 64'(bus.out_valid), 64'h0);
    cycle();
    check("d2_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check("d2_out_valid", 64'(bus.out_valid), 64'h0);
    cycle();
    check("d3_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check("d3_req_addr", bus.imem_req_addr, 64'h1000);
    check("d3_out_valid", 64'(bus.out_valid), 64'h0);
    cycles(4);
    check("post_out_valid", 64'(bus.out_valid), 64'h1);
    check("post_out_pc", bus.out_pc, 64'h1000);
    check("post_out_instr", 64'(bus.out_instr), 64'hC0DE_1000);
    cycle();
    check("post2_out_pc", bus.out_pc, 64'h1004);

    // Redirect coincident with a response and an out handshake
    lat = 2;
    do_reset();
    cycles(3);
    check("co_out_valid", 64'(bus.out_valid), 64'h1);
    check("co_out_pc", bus.out_pc, 64'h0);
    check("co_rsp_valid", 64'(bus.imem_rsp_valid), 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2000;
    #1;
    check("co_req_blocked", 64'(bus.imem_req_valid), 64'h0);
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    check("co1_out_valid", 64'(bus.out_valid), 64'h0);
    check("co1_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check("co1_req_addr", bus.imem_req_addr, 64'h2000);
    cycle();
    check("co2_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check("co2_req_addr", bus.imem_req_addr, 64'h2000);
    check("co2_out_valid", 64'(bus.out_valid), 64'h0);

    // Reset with a full queue presenting data
    lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    cycles(5);
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'h1);
    check("pre_rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    reset = 1'b1;
    #1;
    check("rst_comb_req", 64'(bus.imem_req_valid), 64'h0);
    cycle();
    check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    check("midrst_req_addr", bus.imem_req_addr, 64'h0);
    reset = 1'b0;
    #1;
    check("after_rst_req", 64'(bus.imem_req_valid), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
